// File: rtl/mult_arbiter.sv
// Two-requester front end sharing one signed 32x32 multiplier, with a result
// hand-off port that holds its value until the consumer takes it.

module tree_multiplier (
    input  logic signed [31:0] i_a,
    input  logic signed [31:0] i_b,
    output logic signed [63:0] o_p
);
    logic signed [63:0] w_a_ext;
    logic signed [63:0] w_l0 [0:31];
    logic signed [63:0] w_l1 [0:15];
    logic signed [63:0] w_l2 [0:7];
    logic signed [63:0] w_l3 [0:3];
    logic signed [63:0] w_l4 [0:1];

    assign w_a_ext = {{32{i_a[31]}}, i_a};

    // Bit 31 of b carries weight -2^31 in two's complement, so its row is subtracted.
    for (genvar i = 0; i < 32; i++) begin : g_pp
        if (i == 31) begin : g_neg
            assign w_l0[i] = i_b[i] ? -(w_a_ext <<< i) : '0;
        end else begin : g_pos
            assign w_l0[i] = i_b[i] ? (w_a_ext <<< i) : '0;
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_l1
        assign w_l1[k] = w_l0[2*k] + w_l0[2*k+1];
    end
    for (genvar k = 0; k < 8; k++) begin : g_l2
        assign w_l2[k] = w_l1[2*k] + w_l1[2*k+1];
    end
    for (genvar k = 0; k < 4; k++) begin : g_l3
        assign w_l3[k] = w_l2[2*k] + w_l2[2*k+1];
    end
    for (genvar k = 0; k < 2; k++) begin : g_l4
        assign w_l4[k] = w_l3[2*k] + w_l3[2*k+1];
    end

    assign o_p = w_l4[0] + w_l4[1];
endmodule

module mult_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic signed [31:0] req0_a,
    input  logic signed [31:0] req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic signed [31:0] req1_a,
    input  logic signed [31:0] req1_b,
    output logic               req1_ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic signed [63:0] res_data,
    output logic               res_id,
    output logic               busy
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             r_state;
    logic signed [31:0] r_a;
    logic signed [31:0] r_b;
    logic               r_id;
    logic               r_last_grant;
    logic signed [63:0] r_res_data;
    logic               r_res_id;
    logic               r_res_valid;
    logic               r_busy;

    logic               w_pick1;
    logic               w_accept;
    logic signed [63:0] w_prod;

    // Requester 1 wins when alone, or on contention when round-robin says it is its turn.
    assign w_pick1    = req1_valid && (!req0_valid || (RR_EN && !r_last_grant));
    assign req0_ready = !rst && (r_state == S_IDLE) && req0_valid && !w_pick1;
    assign req1_ready = !rst && (r_state == S_IDLE) && w_pick1;
    assign w_accept   = req0_ready || req1_ready;

    tree_multiplier u_mult (
        .i_a (r_a),
        .i_b (r_b),
        .o_p (w_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
            r_res_data   <= '0;
            r_res_id     <= 1'b0;
            r_res_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_pick1 ? req1_a : req0_a;
                        r_b          <= w_pick1 ? req1_b : req0_b;
                        r_id         <= w_pick1;
                        r_last_grant <= w_pick1;
                        r_busy       <= 1'b1;
                        r_state      <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_res_data  <= w_prod;
                    r_res_id    <= r_id;
                    r_res_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign busy      = r_busy;
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: a round-robin instance and a fixed-priority
// instance driven by the same requesters and consumer.

module tb_mult_arbiter;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req0_valid = 1'b0;
    logic signed [31:0] req0_a = '0;
    logic signed [31:0] req0_b = '0;
    logic               req1_valid = 1'b0;
    logic signed [31:0] req1_a = '0;
    logic signed [31:0] req1_b = '0;
    logic               res_ready = 1'b0;

    logic               rr_req0_ready, rr_req1_ready, rr_res_valid, rr_res_id, rr_busy;
    logic signed [63:0] rr_res_data;
    logic               fp_req0_ready, fp_req1_ready, fp_res_valid, fp_res_id, fp_busy;
    logic signed [63:0] fp_res_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_arbiter #(.RR_EN(1'b1)) u_rr (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(rr_req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(rr_req1_ready),
        .res_valid(rr_res_valid), .res_ready(res_ready), .res_data(rr_res_data),
        .res_id(rr_res_id), .busy(rr_busy)
    );

    mult_arbiter #(.RR_EN(1'b0)) u_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(fp_req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(fp_req1_ready),
        .res_valid(fp_res_valid), .res_ready(res_ready), .res_data(fp_res_data),
        .res_id(fp_res_id), .busy(fp_busy)
    );

    // Stimulus-only helpers; comparisons live in the test tasks.
    task automatic issue(input logic id, input logic signed [31:0] a, input logic signed [31:0] b);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic collect(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rr_res_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic handoff();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rr_res_valid, rr_res_id, rr_busy, rr_req0_ready, rr_req1_ready} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {rr_res_valid, rr_res_id, rr_busy, rr_req0_ready, rr_req1_ready});
        end
        n_checks++;
        if (rr_res_data !== 64'sd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0", rr_res_data);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [3:0] rr_ids, fp_ids;
        int got;
        got = 0;
        rr_ids = '0;
        fp_ids = '0;
        req0_a = 32'sd2; req0_b = 32'sd3;
        req1_a = 32'sd4; req1_b = 32'sd5;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            res_ready = 1'b0;
            if (rr_res_valid) begin
                rr_ids[got] = rr_res_id;
                fp_ids[got] = fp_res_id;
                n_checks++;
                if (rr_res_data !== (rr_res_id ? 64'sd20 : 64'sd6)) begin
                    n_fail++;
                    $display("FAIL contention_data: got %0d for id %0d", rr_res_data, rr_res_id);
                end
                got++;
                res_ready = 1'b1;
                if (got == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
        res_ready = 1'b0;
        n_checks++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL contention_count: got %0d results required 4", got);
        end
        n_checks++;
        if (rr_ids !== 4'b1010) begin
            n_fail++;
            $display("FAIL contention_rr_ids: got %b required 1010 (op0 in bit 0)", rr_ids);
        end
        n_checks++;
        if (fp_ids !== 4'b0000) begin
            n_fail++;
            $display("FAIL contention_fp_ids: got %b required 0000", fp_ids);
        end
        @(negedge clk);
    endtask

    task automatic test_single_op();
        logic ok;
        req0_valid = 1'b1; req0_a = 32'sd7; req0_b = -32'sd3;
        #1;
        n_checks++;
        if ({rr_req0_ready, rr_req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL single_ready: got %b required 10", {rr_req0_ready, rr_req1_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        n_checks++;
        if ({rr_busy, rr_res_valid, rr_req0_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL single_calc: busy/valid/ready got %b required 100",
                     {rr_busy, rr_res_valid, rr_req0_ready});
        end
        @(negedge clk);
        n_checks++;
        if (rr_res_valid !== 1'b1 || rr_res_data !== 64'hFFFF_FFFF_FFFF_FFEB || rr_res_id !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: valid %b data %h id %b required 1 ffffffffffffffeb 0",
                     rr_res_valid, rr_res_data, rr_res_id);
        end
        handoff();
        n_checks++;
        if ({rr_res_valid, rr_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_after: valid/busy got %b required 00", {rr_res_valid, rr_busy});
        end
        ok = 1'b1;
    endtask

    task automatic test_corners();
        logic signed [31:0] va [3];
        logic signed [31:0] vb [3];
        logic signed [63:0] exp_p [3];
        logic ok;
        va[0] = 32'h8000_0000; vb[0] = 32'h8000_0000; exp_p[0] = 64'h4000_0000_0000_0000;
        va[1] = 32'h7FFF_FFFF; vb[1] = 32'h8000_0000; exp_p[1] = 64'hC000_0000_8000_0000;
        va[2] = 32'h0000_0000; vb[2] = 32'hFFFF_FFFF; exp_p[2] = 64'h0;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, va[i], vb[i]);
            collect(ok);
            n_checks++;
            if (!ok || rr_res_data !== exp_p[i]) begin
                n_fail++;
                $display("FAIL corner_%0d: seen %b data %h required %h", i, ok, rr_res_data, exp_p[i]);
            end
            handoff();
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        issue(1'b1, -32'sd2, 32'sd100);
        collect(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_result: no res_valid seen");
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if ({rr_res_valid, rr_busy, rr_req0_ready, rr_req1_ready, rr_res_id} !== 5'b11001
                || rr_res_data !== 64'hFFFF_FFFF_FFFF_FF38) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: v/b/r0/r1/id %b data %h required 11001 ffffffffffffff38", i,
                         {rr_res_valid, rr_busy, rr_req0_ready, rr_req1_ready, rr_res_id}, rr_res_data);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        handoff();
        n_checks++;
        if ({rr_res_valid, rr_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_release: valid/busy got %b required 00", {rr_res_valid, rr_busy});
        end
    endtask

    task automatic test_operand_change();
        logic ok;
        req1_valid = 1'b1; req1_a = 32'sd5; req1_b = 32'sd6;
        @(negedge clk);
        req1_a = 32'sd9; req1_b = 32'sd9;
        req1_valid = 1'b0;
        collect(ok);
        n_checks++;
        if (!ok || rr_res_data !== 64'sd30 || rr_res_id !== 1'b1) begin
            n_fail++;
            $display("FAIL operand_change: seen %b data %0d id %b required 30 id 1", ok, rr_res_data, rr_res_id);
        end
        handoff();
    endtask

    task automatic test_reset_mid_op();
        logic seen;
        issue(1'b0, 32'sd3, 32'sd3);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rr_busy, rr_res_valid, rr_res_id} !== 3'b000 || rr_res_data !== 64'sd0) begin
            n_fail++;
            $display("FAIL midop_reset: busy/valid/id %b data %h required 000 0",
                     {rr_busy, rr_res_valid, rr_res_id}, rr_res_data);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rr_res_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_no_result: res_valid observed after reset");
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_checks++;
        if ({rr_req0_ready, rr_req1_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL midop_grant: got %b required 10", {rr_req0_ready, rr_req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_op();
        test_corners();
        test_backpressure();
        test_operand_change();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
